uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter for debug/telemetry streaming. Accepts words over a

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state encoding and the
// standard divider for 115200 baud from a 50 MHz clock.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int BAUD_DIV_115K2_50M = 434;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
// Pushes are ignored when full and pops when empty, so callers may hold requests.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Flags come from registers only, so a full FIFO refuses a push even when it is popped that cycle.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised LSB first
// with optional parity and one or two stop bits; tx_en gates the start of new frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = BAUD_DIV_115K2_50M,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       tx_en,
  output logic                       uart_tx,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 bit_done, start_frame;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bit_done = (baud_q == BAUD_LAST);

  // The line level is decided from the current state and registered, so it trails the state by one clock.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    line_d      = 1'b1;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      TX_IDLE: begin
        start_frame = tx_en && !fifo_empty;
      end
      TX_START: begin
        line_d = 1'b0;
        baud_d = bit_done ? '0 : baud_q + BW'(1);
        if (bit_done) begin
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        line_d = shift_q[0];
        baud_d = bit_done ? '0 : baud_q + BW'(1);
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      TX_PARITY: begin
        line_d = parity_q;
        baud_d = bit_done ? '0 : baud_q + BW'(1);
        if (bit_done) begin
          bit_d   = '0;
          state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        line_d = 1'b1;
        baud_d = bit_done ? '0 : baud_q + BW'(1);
        if (bit_done) begin
          if (bit_q == STOP_LAST) begin
            state_d     = TX_IDLE;
            start_frame = tx_en && !fifo_empty;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      parity_d = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      baud_d   = '0;
      bit_d    = '0;
      state_d  = TX_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      line_q   <= line_d;
    end
  end

  assign in_ready = ~fifo_full;
  assign uart_tx  = line_q;
  assign tx_busy  = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: three small-divider transmitters (no parity, even/2 stop, odd) share one
// stimulus stream and are checked clock-by-clock; a 16-bit/434 instance checks the full-size frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] inData = '0;
  logic       inValid = 1'b0;
  logic       txEn = 1'b0;

  logic       inReady [3];
  logic       txLine [3];
  logic       txBusy [3];
  logic [2:0] fifoLevel [3];

  logic [15:0] in16Data = '0;
  logic        in16Valid = 1'b0;
  logic        in16Ready, tx16, busy16;
  logic [3:0]  level16;

  int checks = 0;
  int errors = 0;
  int frames [3] = '{0, 0, 0};
  int zeroGaps [3] = '{0, 0, 0};
  int pending [3] = '{0, 0, 0};
  int busy16Cnt = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dutNone (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(inReady[0]),
    .tx_en(txEn), .uart_tx(txLine[0]), .tx_busy(txBusy[0]), .fifo_level(fifoLevel[0]));

  uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) dutEven (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(inReady[1]),
    .tx_en(txEn), .uart_tx(txLine[1]), .tx_busy(txBusy[1]), .fifo_level(fifoLevel[1]));

  uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dutOdd (
    .clk(clk), .rst_n(rstN), .in_data(inData), .in_valid(inValid), .in_ready(inReady[2]),
    .tx_en(txEn), .uart_tx(txLine[2]), .tx_busy(txBusy[2]), .fifo_level(fifoLevel[2]));

  uart_tx_fifo #(.DATA_BITS(16), .BAUD_DIV(434), .PARITY(0), .STOP_BITS(1), .DEPTH(8)) dutWide (
    .clk(clk), .rst_n(rstN), .in_data(in16Data), .in_valid(in16Valid), .in_ready(in16Ready),
    .tx_en(txEn), .uart_tx(tx16), .tx_busy(busy16), .fifo_level(level16));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Each monitor queues accepted words and compares every captured frame sample-for-sample.
  for (genvar g = 0; g < 3; g++) begin : gMon
    localparam int PAR   = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
    localparam int STOPS = (g == 1) ? 2 : 1;
    localparam int NCLK  = (1 + 8 + ((PAR != 0) ? 1 : 0) + STOPS) * 4;

    logic [7:0]  expQ [$];
    bit          capturing = 1'b0;
    int          cnt = 0;
    int          idle = 0;
    logic [63:0] samples, wave;
    logic [15:0] fbits;
    logic [7:0]  w;

    always @(negedge clk) begin
      if (!rstN) begin
        capturing = 1'b0;
        idle = 0;
        expQ.delete();
      end else begin
        if (inValid && inReady[g]) expQ.push_back(inData);
        if (!capturing) begin
          if (txLine[g] == 1'b0) begin
            capturing = 1'b1;
            samples = '0;
            samples[0] = txLine[g];
            cnt = 1;
            if (idle == 0) zeroGaps[g]++;
            idle = 0;
          end else begin
            idle++;
          end
        end else begin
          samples[cnt] = txLine[g];
          cnt++;
          if (cnt == NCLK) begin
            capturing = 1'b0;
            frames[g]++;
            checkOutput($sformatf("dut%0d word queued for frame", g), 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
              w = expQ.pop_front();
              fbits = '1;
              fbits[0] = 1'b0;
              for (int i = 0; i < 8; i++) fbits[1 + i] = w[i];
              if (PAR == 1) fbits[9] = ^w;
              if (PAR == 2) fbits[9] = ~^w;
              wave = '0;
              for (int s = 0; s < NCLK; s++) wave[s] = fbits[s / 4];
              checkOutput($sformatf("dut%0d frame 0x%0h", g, w), samples, wave);
            end
          end
        end
      end
      pending[g] = expQ.size();
    end
  end

  always @(negedge clk) begin
    if (busy16) busy16Cnt++;
  end

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    inData = data;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((txBusy[0] || txBusy[1] || txBusy[2] || fifoLevel[0] != 0 ||
            fifoLevel[1] != 0 || fifoLevel[2] != 0) && t < 2000) begin
      waitClocks(1);
      t++;
    end
    checkOutput("drain within bound", 64'(t < 2000), 64'd1);
    waitClocks(3);
  endtask

  initial begin
    int f0, z0, t;
    logic [17:0] rx, exp18;
    logic [15:0] word16;

    // Reset state
    waitClocks(2);
    checkOutput("reset uart_tx", txLine[0], 1'b1);
    checkOutput("reset tx_busy", txBusy[0], 1'b0);
    checkOutput("reset in_ready", inReady[0], 1'b1);
    checkOutput("reset fifo_level", fifoLevel[0], 3'd0);
    rstN = 1'b1;
    waitClocks(2);

    // Single frame and push-to-start latency
    txEn = 1'b1;
    inData = 8'hA5;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("line after edge N", txLine[0], 1'b1);
    waitClocks(1);
    checkOutput("line after edge N+1", txLine[0], 1'b1);
    checkOutput("busy after edge N+1", txBusy[0], 1'b1);
    waitClocks(1);
    checkOutput("line after edge N+2", txLine[0], 1'b0);
    waitDrain();

    // Parity variants
    applyStimulus(8'h07);
    waitDrain();
    applyStimulus(8'h5B);
    waitDrain();

    // Hold with tx_en low, overfill, then release back-to-back
    txEn = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    waitClocks(1);
    checkOutput("full in_ready", inReady[0], 1'b0);
    checkOutput("full fifo_level", fifoLevel[0], 3'd4);
    checkOutput("held line idle", txLine[0], 1'b1);
    checkOutput("held tx_busy", txBusy[0], 1'b0);
    f0 = frames[0];
    z0 = zeroGaps[0];
    txEn = 1'b1;
    t = 0;
    while (frames[0] < f0 + 4 && t < 400) begin
      waitClocks(1);
      t++;
    end
    checkOutput("four frames sent", 64'(frames[0] - f0), 64'd4);
    checkOutput("back-to-back gaps", 64'(zeroGaps[0] - z0), 64'd3);
    checkOutput("level after burst", fifoLevel[0], 3'd0);
    waitDrain();

    // Simultaneous push and pop, then pointer wrap
    txEn = 1'b0;
    applyStimulus(8'h21);
    applyStimulus(8'h22);
    checkOutput("level before push+pop", fifoLevel[0], 3'd2);
    txEn = 1'b1;
    applyStimulus(8'h23);
    checkOutput("level after push+pop", fifoLevel[0], 3'd2);
    for (int i = 0; i < 10; i++) begin
      t = 0;
      while (!inReady[0] && t < 500) begin
        waitClocks(1);
        t++;
      end
      checkOutput("in_ready within bound", inReady[0], 1'b1);
      applyStimulus(8'h30 + 8'(i * 7));
    end
    waitDrain();

    // Reset in the middle of the data bits
    applyStimulus(8'hC3);
    applyStimulus(8'h5A);
    t = 0;
    while (txLine[0] && t < 20) begin
      waitClocks(1);
      t++;
    end
    checkOutput("frame started", txLine[0], 1'b0);
    waitClocks(12);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort uart_tx", {txLine[0], txLine[1], txLine[2]}, 3'b111);
    checkOutput("abort tx_busy", {txBusy[0], txBusy[1], txBusy[2]}, 3'b000);
    checkOutput("abort fifo_level", fifoLevel[0], 3'd0);
    waitClocks(2);
    rstN = 1'b1;
    waitClocks(2);
    f0 = frames[0];
    applyStimulus(8'h96);
    waitDrain();
    checkOutput("clean frame after reset", 64'(frames[0] - f0), 64'd1);

    // Full-size 16-bit frame at the real divider
    word16 = 16'h8001;
    busy16Cnt = 0;
    in16Data = word16;
    in16Valid = 1'b1;
    @(posedge clk);
    #1;
    in16Valid = 1'b0;
    t = 0;
    while (tx16 && t < 10) begin
      waitClocks(1);
      t++;
    end
    checkOutput("wide start seen", tx16, 1'b0);
    waitClocks(217);
    rx[0] = tx16;
    for (int k = 1; k < 18; k++) begin
      waitClocks(434);
      rx[k] = tx16;
    end
    exp18 = {1'b1, word16, 1'b0};
    checkOutput("wide frame bits", rx, exp18);
    waitClocks(450);
    checkOutput("wide busy clocks", 64'(busy16Cnt), 64'd7812);

    for (int g = 0; g < 3; g++) checkOutput($sformatf("dut%0d words left", g), 64'(pending[g]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
